frame_swap_controller: RTL and testbench

FRAME_SWAP_CONTROLLER -- requirements
Module: frame_swap_controller

---
 rtl/types_pkg.sv | 22 ++
 rtl/frame_swap_controller_buffer_index_queue.sv | 58 +++++
 rtl/frame_swap_controller.sv | 144 ++++++++++++++
 tb/tb_frame_swap_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the frame swap controller: swap policy and per-buffer ownership state.
package types_pkg;

  typedef enum logic [1:0] {
    SWAP_FIFO      = 2'd0,
    SWAP_LATEST    = 2'd1,
    SWAP_IMMEDIATE = 2'd2
  } swap_mode_t;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_DRAWING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_DISPLAY = 2'd3
  } buffer_state_t;

  // The unused encoding 3 behaves as SWAP_FIFO.
  function automatic swap_mode_t decode_mode(input logic [1:0] m);
    return (m == 2'd3) ? SWAP_FIFO : swap_mode_t'(m);
  endfunction

endpackage

// File: rtl/frame_swap_controller_buffer_index_queue.sv
// Completion-ordered queue of READY buffer indices; slot 0 is always the oldest entry.
module buffer_index_queue #(
  parameter int DEPTH = 2,
  parameter int IDX_W = 2
) (
  input  logic             clk_system,
  input  logic             rstn_system,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop_oldest,
  input  logic             pop_newest,
  input  logic             flush,
  output logic [IDX_W-1:0] oldest_idx,
  output logic [IDX_W-1:0] newest_idx,
  output logic [IDX_W:0]   count
);

  localparam int CW = IDX_W + 1;

  logic [IDX_W-1:0] slot     [DEPTH];
  logic [IDX_W-1:0] slot_nxt [DEPTH];
  logic [CW-1:0]    count_nxt;

  // Push is applied before the pops so a same-cycle push is visible to a pop.
  always_comb begin
    slot_nxt  = slot;
    count_nxt = count;
    if (push && count_nxt < CW'(DEPTH)) begin
      for (int i = 0; i < DEPTH; i++)
        if (CW'(i) == count_nxt) slot_nxt[i] = push_idx;
      count_nxt = count_nxt + 1'b1;
    end
    if (pop_oldest && count_nxt != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) slot_nxt[i] = slot_nxt[i+1];
      count_nxt = count_nxt - 1'b1;
    end
    if (pop_newest && count_nxt != '0) count_nxt = count_nxt - 1'b1;
    if (flush) count_nxt = '0;
  end

  always_comb begin
    newest_idx = slot[0];
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i + 1) == count) newest_idx = slot[i];
  end

  assign oldest_idx = slot[0];

  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) count <= '0;
    else              count <= count_nxt;
  end

  always_ff @(posedge clk_system) begin
    slot <= slot_nxt;
  end

endmodule

// File: rtl/frame_swap_controller.sv
// Multi-buffer frame swap controller: hands buffers to the drawer and swaps the display per policy.
module frame_swap_controller
  import types_pkg::*;
#(
  parameter int NUM_BUFFERS = 3,
  parameter int IDX_W       = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_system,
  input  logic             rstn_system,
  input  logic [1:0]       mode,
  input  logic             vsync_pulse,
  input  logic             frame_done,
  output logic             draw_start,
  output logic [IDX_W-1:0] draw_idx,
  output logic [IDX_W-1:0] disp_idx,
  output logic             swap_pulse,
  output logic [IDX_W:0]   ready_count,
  output logic [CNT_W-1:0] dropped_count
);

  localparam int CW = IDX_W + 1;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_START   = 2'd2;
  localparam logic [1:0] ST_DRAWING = 2'd3;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CW-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W + 1)'(b);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  logic [1:0]       st, st_nxt;
  buffer_state_t    bs     [NUM_BUFFERS];
  buffer_state_t    bs_nxt [NUM_BUFFERS];
  swap_mode_t       mode_eff;
  logic             fd_valid, push, imm_fire, swap_fire, latest_swap, any_swap;
  logic             claim, steal, free_found;
  logic [IDX_W-1:0] free_idx, q_oldest, q_newest, eff_oldest, eff_newest, new_disp;
  logic [CW-1:0]    q_count, eff_count, drop_inc;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--)
      if (bs[i] == BUF_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
  end

  // A just-finished frame counts as queued for a vsync in the same cycle.
  always_comb begin
    mode_eff    = decode_mode(mode);
    fd_valid    = frame_done && (st == ST_DRAWING);
    push        = fd_valid && (mode_eff != SWAP_IMMEDIATE);
    imm_fire    = fd_valid && (mode_eff == SWAP_IMMEDIATE);
    eff_count   = q_count + CW'(push);
    swap_fire   = vsync_pulse && (mode_eff != SWAP_IMMEDIATE) && (eff_count != '0);
    latest_swap = swap_fire && (mode_eff == SWAP_LATEST);
    any_swap    = swap_fire || imm_fire;
    eff_oldest  = (q_count == '0) ? draw_idx : q_oldest;
    eff_newest  = push ? draw_idx : q_newest;
    claim       = (st == ST_ACQUIRE) && !any_swap && free_found;
    steal       = (st == ST_ACQUIRE) && !any_swap && !free_found &&
                  (mode_eff != SWAP_FIFO) && (q_count != '0);
    case (mode_eff)
      SWAP_LATEST:    new_disp = eff_newest;
      SWAP_IMMEDIATE: new_disp = draw_idx;
      default:        new_disp = eff_oldest;
    endcase
    drop_inc = '0;
    if (steal)            drop_inc = CW'(1);
    else if (imm_fire)    drop_inc = q_count;
    else if (latest_swap) drop_inc = eff_count - 1'b1;
  end

  always_comb begin
    bs_nxt = bs;
    if (push) bs_nxt[draw_idx] = BUF_READY;
    if (imm_fire || latest_swap)
      for (int i = 0; i < NUM_BUFFERS; i++)
        if (bs_nxt[i] == BUF_READY) bs_nxt[i] = BUF_FREE;
    if (any_swap) begin
      bs_nxt[disp_idx] = BUF_FREE;
      bs_nxt[new_disp] = BUF_DISPLAY;
    end
    if (claim) bs_nxt[free_idx] = BUF_DRAWING;
    if (steal) bs_nxt[q_oldest] = BUF_DRAWING;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:    st_nxt = ST_ACQUIRE;
      ST_ACQUIRE: if (claim || steal) st_nxt = ST_START;
      ST_START:   st_nxt = ST_DRAWING;
      ST_DRAWING: if (fd_valid) st_nxt = ST_ACQUIRE;
      default:    st_nxt = ST_IDLE;
    endcase
  end

  buffer_index_queue #(
    .DEPTH (NUM_BUFFERS - 1),
    .IDX_W (IDX_W)
  ) u_ready_queue (
    .clk_system  (clk_system),
    .rstn_system (rstn_system),
    .push        (push),
    .push_idx    (draw_idx),
    .pop_oldest  ((swap_fire && (mode_eff == SWAP_FIFO)) || steal),
    .pop_newest  (1'b0),
    .flush       (imm_fire || latest_swap),
    .oldest_idx  (q_oldest),
    .newest_idx  (q_newest),
    .count       (q_count)
  );

  assign ready_count = q_count;

  always_ff @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) begin
      st            <= ST_IDLE;
      draw_idx      <= IDX_W'(1);
      disp_idx      <= '0;
      draw_start    <= 1'b0;
      swap_pulse    <= 1'b0;
      dropped_count <= '0;
      for (int i = 0; i < NUM_BUFFERS; i++)
        bs[i] <= (i == 0) ? BUF_DISPLAY : BUF_FREE;
    end else begin
      st            <= st_nxt;
      bs            <= bs_nxt;
      draw_start    <= (st == ST_START);
      swap_pulse    <= any_swap;
      dropped_count <= sat_add(dropped_count, drop_inc);
      if (any_swap) disp_idx <= new_disp;
      if (claim)      draw_idx <= free_idx;
      else if (steal) draw_idx <= q_oldest;
    end
  end

endmodule

// File: tb/tb_frame_swap_controller.sv
// Directed bench for frame_swap_controller across 2, 3 and 4 buffers plus a narrow drop counter.
module tb_frame_swap_controller;

  logic clk_system = 1'b0;
  always #5 clk_system = ~clk_system;

  logic       rstn_system;
  logic [1:0] mode;
  logic       vsync_pulse, frame_done;

  logic       ds2, sp2;
  logic [0:0] draw2, disp2;
  logic [1:0] rc2;
  logic [15:0] dc2;

  logic       ds3, sp3;
  logic [1:0] draw3, disp3;
  logic [2:0] rc3;
  logic [15:0] dc3;

  logic       ds3s, sp3s;
  logic [1:0] draw3s, disp3s;
  logic [2:0] rc3s;
  logic [1:0] dc3s;

  logic       ds4, sp4;
  logic [1:0] draw4, disp4;
  logic [2:0] rc4;
  logic [15:0] dc4;

  int vectors, miscompares, cyc;

  frame_swap_controller #(.NUM_BUFFERS(2), .IDX_W(1), .CNT_W(16)) u2 (
    .clk_system(clk_system), .rstn_system(rstn_system), .mode(mode),
    .vsync_pulse(vsync_pulse), .frame_done(frame_done), .draw_start(ds2),
    .draw_idx(draw2), .disp_idx(disp2), .swap_pulse(sp2),
    .ready_count(rc2), .dropped_count(dc2));

  frame_swap_controller #(.NUM_BUFFERS(3), .IDX_W(2), .CNT_W(16)) u3 (
    .clk_system(clk_system), .rstn_system(rstn_system), .mode(mode),
    .vsync_pulse(vsync_pulse), .frame_done(frame_done), .draw_start(ds3),
    .draw_idx(draw3), .disp_idx(disp3), .swap_pulse(sp3),
    .ready_count(rc3), .dropped_count(dc3));

  frame_swap_controller #(.NUM_BUFFERS(3), .IDX_W(2), .CNT_W(2)) u3s (
    .clk_system(clk_system), .rstn_system(rstn_system), .mode(mode),
    .vsync_pulse(vsync_pulse), .frame_done(frame_done), .draw_start(ds3s),
    .draw_idx(draw3s), .disp_idx(disp3s), .swap_pulse(sp3s),
    .ready_count(rc3s), .dropped_count(dc3s));

  frame_swap_controller #(.NUM_BUFFERS(4), .IDX_W(2), .CNT_W(16)) u4 (
    .clk_system(clk_system), .rstn_system(rstn_system), .mode(mode),
    .vsync_pulse(vsync_pulse), .frame_done(frame_done), .draw_start(ds4),
    .draw_idx(draw4), .disp_idx(disp4), .swap_pulse(sp4),
    .ready_count(rc4), .dropped_count(dc4));

  // cyc == k in the window just after the k-th rising edge following reset release.
  always @(posedge clk_system or negedge rstn_system) begin
    if (!rstn_system) cyc <= 0;
    else              cyc <= cyc + 1;
  end

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk_system);
      #1;
    end
  endtask

  task automatic pulse(input int k, input logic fd, input logic vs);
    goto(k - 1);
    frame_done  = fd;
    vsync_pulse = vs;
    @(posedge clk_system);
    #1;
    frame_done  = 1'b0;
    vsync_pulse = 1'b0;
  endtask

  task automatic apply_reset(input logic [1:0] m);
    rstn_system = 1'b0;
    frame_done  = 1'b0;
    vsync_pulse = 1'b0;
    mode        = m;
    repeat (2) @(posedge clk_system);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk_system);
    rstn_system = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset(2'd0);
    vectors++; if (disp3 !== 2'd0) begin miscompares++; $display("FAIL rst_disp: got %0d want 0", disp3); end
    vectors++; if (draw3 !== 2'd1) begin miscompares++; $display("FAIL rst_draw: got %0d want 1", draw3); end
    vectors++; if (draw2 !== 1'b1) begin miscompares++; $display("FAIL rst_draw2: got %0d want 1", draw2); end
    vectors++; if ({ds3, sp3} !== 2'b00) begin miscompares++; $display("FAIL rst_pulses: got %b want 00", {ds3, sp3}); end
    vectors++; if (rc3 !== 3'd0 || dc3 !== 16'd0) begin miscompares++; $display("FAIL rst_counts: got %0d/%0d want 0/0", rc3, dc3); end
    release_reset();
    goto(2);
    vectors++; if (ds3 !== 1'b0) begin miscompares++; $display("FAIL start_early: got %0d want 0", ds3); end
    goto(3);
    vectors++; if (ds3 !== 1'b1 || draw3 !== 2'd1) begin miscompares++; $display("FAIL start_c3: got ds=%0d idx=%0d want ds=1 idx=1", ds3, draw3); end
    goto(4);
    vectors++; if (ds3 !== 1'b0) begin miscompares++; $display("FAIL start_once: got %0d want 0", ds3); end
  endtask

  task automatic test_fifo_two_buffers();
    apply_reset(2'd0);
    release_reset();
    pulse(100, 1'b1, 1'b0);
    vectors++; if (rc2 !== 2'd1 || sp2 !== 1'b0 || disp2 !== 1'b0) begin miscompares++; $display("FAIL n2_done: got rc=%0d sp=%0d disp=%0d want 1/0/0", rc2, sp2, disp2); end
    goto(499);
    vectors++; if (draw2 !== 1'b1 || ds2 !== 1'b0) begin miscompares++; $display("FAIL n2_stall: got idx=%0d ds=%0d want 1/0", draw2, ds2); end
    pulse(500, 1'b0, 1'b1);
    vectors++; if (sp2 !== 1'b1 || disp2 !== 1'b1 || rc2 !== 2'd0) begin miscompares++; $display("FAIL n2_swap: got sp=%0d disp=%0d rc=%0d want 1/1/0", sp2, disp2, rc2); end
    goto(501);
    vectors++; if (sp2 !== 1'b0 || ds2 !== 1'b0) begin miscompares++; $display("FAIL n2_501: got sp=%0d ds=%0d want 0/0", sp2, ds2); end
    goto(502);
    vectors++; if (ds2 !== 1'b1 || draw2 !== 1'b0) begin miscompares++; $display("FAIL n2_restart: got ds=%0d idx=%0d want 1/0", ds2, draw2); end
  endtask

  task automatic test_fifo_stall();
    int starts;
    apply_reset(2'd0);
    release_reset();
    pulse(10, 1'b1, 1'b0);
    goto(12);
    vectors++; if (ds3 !== 1'b1 || draw3 !== 2'd2) begin miscompares++; $display("FAIL stall_claim2: got ds=%0d idx=%0d want 1/2", ds3, draw3); end
    pulse(20, 1'b1, 1'b0);
    starts = 0;
    for (int c = 21; c < 40; c++) begin
      goto(c);
      if (ds3) starts++;
    end
    vectors++; if (starts !== 0 || rc3 !== 3'd2 || draw3 !== 2'd2) begin miscompares++; $display("FAIL stall_hold: got starts=%0d rc=%0d idx=%0d want 0/2/2", starts, rc3, draw3); end
    pulse(40, 1'b0, 1'b1);
    vectors++; if (sp3 !== 1'b1 || disp3 !== 2'd1 || rc3 !== 3'd1) begin miscompares++; $display("FAIL stall_swap: got sp=%0d disp=%0d rc=%0d want 1/1/1", sp3, disp3, rc3); end
    goto(42);
    vectors++; if (ds3 !== 1'b1 || draw3 !== 2'd0) begin miscompares++; $display("FAIL stall_resume: got ds=%0d idx=%0d want 1/0", ds3, draw3); end
  endtask

  task automatic test_latest();
    apply_reset(2'd1);
    release_reset();
    pulse(10, 1'b1, 1'b0);
    pulse(20, 1'b1, 1'b0);
    goto(21);
    vectors++; if (dc3 !== 16'd1 || rc3 !== 3'd1 || draw3 !== 2'd1) begin miscompares++; $display("FAIL latest_steal: got dc=%0d rc=%0d idx=%0d want 1/1/1", dc3, rc3, draw3); end
    goto(22);
    vectors++; if (ds3 !== 1'b1) begin miscompares++; $display("FAIL latest_nostall: got %0d want 1", ds3); end
    pulse(30, 1'b1, 1'b0);
    pulse(31, 1'b0, 1'b1);
    vectors++; if (sp3 !== 1'b1 || disp3 !== 2'd1 || dc3 !== 16'd2 || rc3 !== 3'd0) begin miscompares++; $display("FAIL latest_swap: got sp=%0d disp=%0d dc=%0d rc=%0d want 1/1/2/0", sp3, disp3, dc3, rc3); end
    goto(33);
    vectors++; if (ds3 !== 1'b1 || draw3 !== 2'd0) begin miscompares++; $display("FAIL latest_resume: got ds=%0d idx=%0d want 1/0", ds3, draw3); end
    pulse(40, 1'b1, 1'b0);
    pulse(50, 1'b1, 1'b0);
    pulse(60, 1'b1, 1'b0);
    goto(61);
    vectors++; if (dc3 !== 16'd4 || dc3s !== 2'd3) begin miscompares++; $display("FAIL sat_reach: got dc=%0d dcs=%0d want 4/3", dc3, dc3s); end
    pulse(70, 1'b1, 1'b0);
    goto(71);
    vectors++; if (dc3 !== 16'd5 || dc3s !== 2'd3 || draw3 !== 2'd0) begin miscompares++; $display("FAIL sat_hold: got dc=%0d dcs=%0d idx=%0d want 5/3/0", dc3, dc3s, draw3); end
  endtask

  task automatic test_same_cycle();
    apply_reset(2'd0);
    release_reset();
    pulse(10, 1'b1, 1'b1);
    vectors++; if (sp3 !== 1'b1 || disp3 !== 2'd1 || rc3 !== 3'd0) begin miscompares++; $display("FAIL same_swap: got sp=%0d disp=%0d rc=%0d want 1/1/0", sp3, disp3, rc3); end
    goto(12);
    vectors++; if (ds3 !== 1'b1 || draw3 !== 2'd0) begin miscompares++; $display("FAIL same_next: got ds=%0d idx=%0d want 1/0", ds3, draw3); end
  endtask

  task automatic test_immediate();
    apply_reset(2'd2);
    release_reset();
    pulse(10, 1'b1, 1'b0);
    vectors++; if (sp4 !== 1'b1 || disp4 !== 2'd1 || rc4 !== 3'd0) begin miscompares++; $display("FAIL imm_swap: got sp=%0d disp=%0d rc=%0d want 1/1/0", sp4, disp4, rc4); end
    goto(12);
    vectors++; if (ds4 !== 1'b1 || draw4 !== 2'd0) begin miscompares++; $display("FAIL imm_claim: got ds=%0d idx=%0d want 1/0", ds4, draw4); end
    pulse(20, 1'b0, 1'b1);
    vectors++; if (sp4 !== 1'b0 || disp4 !== 2'd1) begin miscompares++; $display("FAIL imm_vsync: got sp=%0d disp=%0d want 0/1", sp4, disp4); end
    pulse(30, 1'b1, 1'b0);
    vectors++; if (sp4 !== 1'b1 || disp4 !== 2'd0 || dc4 !== 16'd0) begin miscompares++; $display("FAIL imm_second: got sp=%0d disp=%0d dc=%0d want 1/0/0", sp4, disp4, dc4); end
    goto(31);
    vectors++; if (sp4 !== 1'b0) begin miscompares++; $display("FAIL imm_pulse_once: got %0d want 0", sp4); end
  endtask

  task automatic test_reset_midframe();
    apply_reset(2'd1);
    release_reset();
    pulse(10, 1'b1, 1'b0);
    pulse(20, 1'b1, 1'b0);
    pulse(30, 1'b1, 1'b0);
    vectors++; if (rc3 !== 3'd2 || dc3 !== 16'd1) begin miscompares++; $display("FAIL mid_pre: got rc=%0d dc=%0d want 2/1", rc3, dc3); end
    rstn_system = 1'b0;
    #2;
    vectors++; if (rc3 !== 3'd0 || dc3 !== 16'd0) begin miscompares++; $display("FAIL mid_counts: got rc=%0d dc=%0d want 0/0", rc3, dc3); end
    vectors++; if (disp3 !== 2'd0 || draw3 !== 2'd1 || ds3 !== 1'b0 || sp3 !== 1'b0) begin miscompares++; $display("FAIL mid_outs: got disp=%0d idx=%0d ds=%0d sp=%0d want 0/1/0/0", disp3, draw3, ds3, sp3); end
    repeat (2) @(posedge clk_system);
    release_reset();
    goto(3);
    vectors++; if (ds3 !== 1'b1 || draw3 !== 2'd1 || rc3 !== 3'd0) begin miscompares++; $display("FAIL mid_restart: got ds=%0d idx=%0d rc=%0d want 1/1/0", ds3, draw3, rc3); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn_system = 1'b0;
    mode        = 2'd0;
    frame_done  = 1'b0;
    vsync_pulse = 1'b0;
    test_reset();
    test_fifo_two_buffers();
    test_fifo_stall();
    test_latest();
    test_same_cycle();
    test_immediate();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
